// File: rtl/alu_seq_muldiv.sv
// Sequential ALU: single-cycle shift/logic/arith ops, iterative unsigned MULT/DIV into HI/LO.
// Optional ALU_SRA_EN: adds funct 0x03 (arithmetic right shift) and makes 0x2A a signed compare.
module alu_seq_muldiv #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [5:0]         funct,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out,
  output logic               busy
);

  localparam int CNT_W = SHAMT_W + 1;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_MFHI = 6'h10;
  localparam logic [5:0] F_MFLO = 6'h12;
  localparam logic [5:0] F_MULT = 6'h18;
  localparam logic [5:0] F_DIV  = 6'h1A;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   work_hi_q, work_hi_d;
  logic [WIDTH-1:0]   work_lo_q, work_lo_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH-1:0]   out_q, out_d;
  logic               out_valid_q, out_valid_d;

  logic               lt;
  logic [WIDTH-1:0]   alu_res;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   nxt_hi, nxt_lo;

  always_comb begin
`ifdef ALU_SRA_EN
    lt = $signed(a) < $signed(b);
`else
    lt = a < b;
`endif
    alu_res = '0;
    case (funct)
      F_SLL:  alu_res = a << shamt;
      F_SRL:  alu_res = a >> shamt;
`ifdef ALU_SRA_EN
      F_SRA:  alu_res = $signed(a) >>> shamt;
`endif
      F_MFHI: alu_res = hi_q;
      F_MFLO: alu_res = lo_q;
      F_ADD:  alu_res = a + b;
      F_SUB:  alu_res = a - b;
      F_AND:  alu_res = a & b;
      F_OR:   alu_res = a | b;
      F_XOR:  alu_res = a ^ b;
      F_NOR:  alu_res = ~(a | b);
      F_SLT:  alu_res[0] = lt;
      default: alu_res = '0;
    endcase
  end

  // MUL: work_hi:work_lo is the shifting product, multiplier starts in work_lo.
  // DIV: work_hi is the partial remainder, work_lo shifts dividend out and quotient in.
  always_comb begin
    mul_sum   = {1'b0, work_hi_q} + (work_lo_q[0] ? {1'b0, opb_q} : '0);
    div_shift = {work_hi_q, work_lo_q[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, opb_q};

    nxt_hi = work_hi_q;
    nxt_lo = work_lo_q;
    if (state_q == S_MUL) begin
      nxt_hi = mul_sum[WIDTH:1];
      nxt_lo = {mul_sum[0], work_lo_q[WIDTH-1:1]};
    end else if (state_q == S_DIV) begin
      nxt_hi = div_ge ? WIDTH'(div_shift - {1'b0, opb_q}) : div_shift[WIDTH-1:0];
      nxt_lo = {work_lo_q[WIDTH-2:0], div_ge};
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    work_hi_d   = work_hi_q;
    work_lo_d   = work_lo_q;
    opb_d       = opb_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    out_d       = out_q;
    out_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (funct == F_MULT) begin
            state_d   = S_MUL;
            cnt_d     = CNT_W'(WIDTH - 1);
            work_hi_d = '0;
            work_lo_d = b;
            opb_d     = a;
          end else if (funct == F_DIV) begin
            if (b == '0) begin
              hi_d        = a;
              lo_d        = '1;
              out_d       = '0;
              out_valid_d = 1'b1;
            end else begin
              state_d   = S_DIV;
              cnt_d     = CNT_W'(WIDTH - 1);
              work_hi_d = '0;
              work_lo_d = a;
              opb_d     = b;
            end
          end else begin
            out_d       = alu_res;
            out_valid_d = 1'b1;
          end
        end
      end
      S_MUL, S_DIV: begin
        work_hi_d = nxt_hi;
        work_lo_d = nxt_lo;
        if (cnt_q == '0) begin
          state_d     = S_IDLE;
          hi_d        = nxt_hi;
          lo_d        = nxt_lo;
          out_d       = '0;
          out_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      work_hi_q   <= '0;
      work_lo_q   <= '0;
      opb_q       <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      work_hi_q   <= work_hi_d;
      work_lo_q   <= work_lo_d;
      opb_q       <= opb_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign out       = out_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_alu_seq_muldiv.sv
// Self-checking bench for alu_seq_muldiv: directed cases plus randomized ops against an arithmetic model.
module tb_alu_seq_muldiv;

  localparam int W = 32;

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [5:0]    funct;
  logic [4:0]    shamt;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          out_valid;
  logic [W-1:0]  out;
  logic          busy;

  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  alu_seq_muldiv dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .funct     (funct),
    .shamt     (shamt),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out       (out),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] model_single(input logic [5:0] f, input logic [4:0] sh,
                                                input logic [W-1:0] x, input logic [W-1:0] y);
    longint sx;
    case (f)
      6'h00: return x << sh;
      6'h02: return x >> sh;
`ifdef ALU_SRA_EN
      6'h03: begin
        sx = longint'($signed(x));
        return W'(sx / (longint'(1) << sh) - ((sx < 0 && (sx % (longint'(1) << sh)) != 0) ? 1 : 0));
      end
      6'h2A: return (longint'($signed(x)) < longint'($signed(y))) ? 1 : 0;
`else
      6'h2A: return (x < y) ? 1 : 0;
`endif
      6'h10: return m_hi;
      6'h12: return m_lo;
      6'h20: return x + y;
      6'h22: return x - y;
      6'h24: return x & y;
      6'h25: return x | y;
      6'h26: return x ^ y;
      6'h27: return ~(x | y);
      default: return '0;
    endcase
  endfunction

  task automatic run_op(input string nm, input logic [5:0] f, input logic [4:0] sh,
                        input logic [W-1:0] x, input logic [W-1:0] y, output logic [W-1:0] res);
    logic [W-1:0] exp_out;
    logic [63:0]  prod;
    logic         multi;
    int           lat, bcnt, waitc;
    multi   = (f == 6'h18) || (f == 6'h1A && y != 0);
    exp_out = model_single(f, sh, x, y);
    @(negedge clk);
    funct = f; shamt = sh; a = x; b = y; in_valid = 1'b1;
    waitc = 0;
    while (!in_ready && waitc < 200) begin
      @(negedge clk);
      waitc++;
    end
    check({nm, "_accept"}, 64'(in_ready), 64'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    funct = 6'($urandom); a = $urandom; b = $urandom; shamt = 5'($urandom);
    lat = 1;
    bcnt = 0;
    while (!out_valid && lat < 200) begin
      if (busy && !in_ready) bcnt++;
      @(posedge clk);
      #1;
      lat++;
    end
    res = out;
    check({nm, "_out"}, 64'(out), 64'(exp_out));
    check({nm, "_latency"}, 64'(lat), 64'(multi ? W + 1 : 1));
    check({nm, "_busy_cycles"}, 64'(bcnt), 64'(multi ? W : 0));
    if (f == 6'h18) begin
      prod = {32'b0, x} * {32'b0, y};
      m_hi = prod[63:32];
      m_lo = prod[31:0];
    end else if (f == 6'h1A) begin
      if (y == 0) begin
        m_hi = x;
        m_lo = 32'hFFFF_FFFF;
      end else begin
        m_hi = x % y;
        m_lo = x / y;
      end
    end
    @(posedge clk);
    #1;
    check({nm, "_pulse"}, 64'(out_valid), 64'(0));
    check({nm, "_held"}, 64'(out), 64'(res));
  endtask

  task automatic check_hilo(input string nm);
    logic [W-1:0] r;
    run_op({nm, "_mfhi"}, 6'h10, 5'd0, $urandom, $urandom, r);
    run_op({nm, "_mflo"}, 6'h12, 5'd0, $urandom, $urandom, r);
  endtask

  logic [5:0] codes [16] = '{6'h00, 6'h02, 6'h03, 6'h10, 6'h12, 6'h18, 6'h1A, 6'h20,
                             6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h3F, 6'h01};

  initial begin
    logic [W-1:0] r;
    logic [5:0]   f;
    logic [W-1:0] x, y;
    int           cnt;

    reset = 1'b1; in_valid = 1'b0; funct = '0; shamt = '0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out", 64'(out), 64'(0));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(1));
    @(negedge clk);
    reset = 1'b0;

    run_op("add", 6'h20, 5'd0, 32'd5, 32'd7, r);
    check("add_const", 64'(r), 64'd12);
    run_op("sub", 6'h22, 5'd0, 32'd3, 32'd5, r);
    check("sub_const", 64'(r), 64'hFFFF_FFFE);
    run_op("sll", 6'h00, 5'd31, 32'd1, 32'd0, r);
    check("sll_const", 64'(r), 64'h8000_0000);
    run_op("nor", 6'h27, 5'd0, 32'd0, 32'd0, r);
    check("nor_const", 64'(r), 64'hFFFF_FFFF);
    run_op("bad_funct", 6'h3F, 5'd3, 32'h1234_5678, 32'h9ABC_DEF0, r);
    check("bad_funct_const", 64'(r), 64'd0);

    run_op("mult", 6'h18, 5'd0, 32'hFFFF_FFFF, 32'd2, r);
    run_op("mult_mfhi", 6'h10, 5'd0, 32'd0, 32'd0, r);
    check("mult_hi_const", 64'(r), 64'd1);
    run_op("mult_mflo", 6'h12, 5'd0, 32'd0, 32'd0, r);
    check("mult_lo_const", 64'(r), 64'hFFFF_FFFE);

    run_op("div", 6'h1A, 5'd0, 32'd100, 32'd7, r);
    run_op("div_mfhi", 6'h10, 5'd0, 32'd0, 32'd0, r);
    check("div_hi_const", 64'(r), 64'd2);
    run_op("div_mflo", 6'h12, 5'd0, 32'd0, 32'd0, r);
    check("div_lo_const", 64'(r), 64'd14);

    run_op("div0", 6'h1A, 5'd0, 32'd9, 32'd0, r);
    run_op("div0_mfhi", 6'h10, 5'd0, 32'd0, 32'd0, r);
    check("div0_hi_const", 64'(r), 64'd9);
    run_op("div0_mflo", 6'h12, 5'd0, 32'd0, 32'd0, r);
    check("div0_lo_const", 64'(r), 64'hFFFF_FFFF);

    run_op("sra", 6'h03, 5'd4, 32'h8000_0000, 32'd0, r);
`ifdef ALU_SRA_EN
    check("sra_const", 64'(r), 64'hF800_0000);
`else
    check("sra_const", 64'(r), 64'd0);
`endif
    run_op("slt", 6'h2A, 5'd0, 32'hFFFF_FFFF, 32'd1, r);
`ifdef ALU_SRA_EN
    check("slt_const", 64'(r), 64'd1);
`else
    check("slt_const", 64'(r), 64'd0);
`endif

    // ADD held valid across a DIV: accepted only once the divider returns to idle.
    @(negedge clk);
    funct = 6'h1A; a = 32'd100; b = 32'd7; in_valid = 1'b1;
    @(posedge clk);
    #1;
    funct = 6'h20; a = 32'd20; b = 32'd22;
    cnt = 1;
    while (!out_valid && cnt < 200) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check("hold_div_latency", 64'(cnt), 64'(W + 1));
    check("hold_div_out", 64'(out), 64'd0);
    check("hold_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("hold_add_valid", 64'(out_valid), 64'(1));
    check("hold_add_out", 64'(out), 64'd42);
    m_hi = 32'd2;
    m_lo = 32'd14;
    check_hilo("hold");

    // Reset in the middle of a DIV aborts it and clears HI/LO.
    @(negedge clk);
    funct = 6'h1A; a = 32'd1000; b = 32'd3; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_in_ready", 64'(in_ready), 64'(1));
    check("midrst_out_valid", 64'(out_valid), 64'(0));
    @(negedge clk);
    reset = 1'b0;
    m_hi = '0;
    m_lo = '0;
    check_hilo("midrst");

    for (int i = 0; i < 60; i++) begin
      f = codes[$urandom_range(0, 15)];
      x = $urandom;
      y = $urandom;
      if (f == 6'h1A) begin
        case ($urandom_range(0, 3))
          0: y = '0;
          1: y = 32'($urandom_range(1, 255));
          default: ;
        endcase
      end
      if ($urandom_range(0, 7) == 0) x = '0;
      run_op("rand", f, 5'($urandom), x, y, r);
      if (f == 6'h18 || f == 6'h1A) check_hilo("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1);
  end

endmodule
